// File: rtl/prbs5_pkg.sv
// Shared definitions for the PRBS5 checker and its benches: FSM states,
// LFSR geometry, the reference seed and the generator next-state function.
package prbs5_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int          LFSR_W = 5;
    localparam int          TAP_A  = 0;
    localparam int          TAP_B  = 2;
    localparam logic [4:0]  SEED   = 5'b00001;

    // Generator step: output bit is s[0], feedback enters at the top.
    function automatic logic [LFSR_W-1:0] next_state(input logic [LFSR_W-1:0] s);
        return {s[TAP_A] ^ s[TAP_B], s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/prbs5_predictor.sv
// Window register of the last five received (or predicted) bits plus the
// combinational prediction of the next bit.
import prbs5_pkg::*;

module prbs5_predictor (
    input  logic clk,
    input  logic reset,
    input  logic shift_en,
    input  logic use_pred,
    input  logic win_clr,
    input  logic in_bit,
    output logic p,
    output logic win_zero
);

    logic [LFSR_W-1:0] r;

    assign p        = r[TAP_A] ^ r[TAP_B];
    assign win_zero = (r == '0);

    // Shifting p back in is exactly one generator step, so reuse next_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
        end else if (win_clr) begin
            r <= '0;
        end else if (shift_en) begin
            if (use_pred) begin
                r <= next_state(r);
            end else begin
                r <= {in_bit, r[LFSR_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 stream checker: FILL -> SYNC -> LOCKED lock FSM with bit error pulse.
// Optional error counter built only when PRBS5_CHECKER_ERR_CNT_EN is defined.
import prbs5_pkg::*;

module prbs5_checker #(
    parameter int LOCK_MATCHES = 8,
    parameter int LOSS_ERRORS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output state_t           state_dbg
);

    localparam int MW  = $clog2(LOCK_MATCHES + 1);
    localparam int SW  = $clog2(LOSS_ERRORS + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
    localparam logic [SW-1:0] MISS_LAST  = SW'(LOSS_ERRORS - 1);
    localparam logic [2:0]    FILL_LAST  = 3'(LFSR_W - 1);

    // Input handshake: in_bit is consumed on every rising clk edge where
    // in_valid is high; there is no back-pressure, the checker always accepts.

    state_t         state;
    logic [2:0]     fill_cnt;
    logic [MW-1:0]  match_cnt;
    logic [SW-1:0]  miss_cnt;

    logic p;
    logic win_zero;
    logic hit;
    logic err_event;
    logic shift_en;
    logic use_pred;
    logic win_clr;

    assign hit       = (in_bit == p);
    assign err_event = in_valid && (state == LOCKED) && !hit;
    assign state_dbg = state;

    always_comb begin
        shift_en = in_valid;
        use_pred = (state == LOCKED);
        win_clr  = err_event && (miss_cnt == MISS_LAST);
    end

    prbs5_predictor u_pred (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .use_pred (use_pred),
        .win_clr  (win_clr),
        .in_bit   (in_bit),
        .p        (p),
        .win_zero (win_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
        end else begin
            bit_err <= 1'b0;
            if (in_valid) begin
                case (state)
                    FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state     <= SYNC;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    SYNC: begin
                        // An all-zero window is a dead line, never a valid match.
                        if (hit && !win_zero) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= LOCKED;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                                locked    <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            bit_err <= 1'b1;
                            if (miss_cnt == MISS_LAST) begin
                                state    <= FILL;
                                fill_cnt <= '0;
                                miss_cnt <= '0;
                                locked   <= 1'b0;
                            end else begin
                                miss_cnt <= miss_cnt + SW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS5_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] err_q;

    // Clear takes priority over a coinciding error; the count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (err_event && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// Self-checking bench for prbs5_checker against a queue-based behavioural
// model of the lock rules; adapts to PRBS5_CHECKER_ERR_CNT_EN.
import prbs5_pkg::*;

module tb_prbs5_checker;

    localparam int LOCK_MATCHES = 8;
    localparam int LOSS_ERRORS  = 3;
    localparam int CNT_W        = 4;
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_count;
    state_t           state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int               m_mode;      // 0 fill, 1 sync, 2 locked
    logic             hist[$];     // hist[0] is the oldest bit
    int               m_matches;
    int               m_misses;
    logic             m_bit_err;
    logic [CNT_W-1:0] m_errs;

    logic [4:0] gen_s;

    prbs5_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .LOSS_ERRORS  (LOSS_ERRORS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clr   (err_clr),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode    = 0;
        hist.delete();
        m_matches = 0;
        m_misses  = 0;
        m_bit_err = 1'b0;
        m_errs    = '0;
        gen_s     = SEED;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        logic pred;
        int   ones;
        m_bit_err = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                hist.push_back(b);
                if (hist.size() == 5) begin
                    m_mode    = 1;
                    m_matches = 0;
                end
            end else if (m_mode == 1) begin
                pred = hist[0] ^ hist[2];
                ones = 0;
                foreach (hist[i]) ones += int'(hist[i]);
                if (b == pred && ones != 0) m_matches++;
                else m_matches = 0;
                hist.push_back(b);
                void'(hist.pop_front());
                if (m_matches == LOCK_MATCHES) begin
                    m_mode   = 2;
                    m_misses = 0;
                end
            end else begin
                pred = hist[0] ^ hist[2];
                hist.push_back(pred);
                void'(hist.pop_front());
                if (b != pred) begin
                    m_bit_err = 1'b1;
`ifdef PRBS5_CHECKER_ERR_CNT_EN
                    if (m_errs != ERR_MAX) m_errs = m_errs + 1'b1;
`endif
                    m_misses++;
                    if (m_misses == LOSS_ERRORS) begin
                        m_mode = 0;
                        hist.delete();
                    end
                end else begin
                    m_misses = 0;
                end
            end
        end
`ifdef PRBS5_CHECKER_ERR_CNT_EN
        if (c) m_errs = '0;
`else
        if (c) m_errs = '0;
`endif
    endtask

    task automatic gen_bit(output logic b);
        b     = gen_s[0];
        gen_s = next_state(gen_s);
    endtask

    // driver: one clock cycle, model advanced and outputs compared after the edge
    task automatic cycle(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        err_clr  = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        n_tests++;
        if (locked !== (m_mode == 2)) begin
            n_fail++;
            $display("FAIL locked t=%0t got %b exp %b", $time, locked, (m_mode == 2));
        end
        n_tests++;
        if (bit_err !== m_bit_err) begin
            n_fail++;
            $display("FAIL bit_err t=%0t got %b exp %b", $time, bit_err, m_bit_err);
        end
        n_tests++;
        if (err_count !== m_errs) begin
            n_fail++;
            $display("FAIL err_count t=%0t got %0d exp %0d", $time, err_count, m_errs);
        end
    endtask

    task automatic clean_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (locked !== 1'b0 || bit_err !== 1'b0 || err_count !== '0 || state_dbg !== FILL) begin
            n_fail++;
            $display("FAIL reset_state got locked=%b bit_err=%b cnt=%0d st=%0d exp 0 0 0 FILL",
                     locked, bit_err, err_count, state_dbg);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_clean_lock();
        logic b;
        int lock_at = 0;
        int pulses  = 0;
        for (int i = 1; i <= 100; i++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0);
            if (locked === 1'b1 && lock_at == 0) lock_at = i;
            if (bit_err === 1'b1) pulses++;
        end
        n_tests++;
        if (lock_at != 5 + LOCK_MATCHES) begin
            n_fail++;
            $display("FAIL clean_lock_bit got %0d exp %0d", lock_at, 5 + LOCK_MATCHES);
        end
        n_tests++;
        if (pulses != 0 || err_count !== '0) begin
            n_fail++;
            $display("FAIL clean_no_err got pulses=%0d cnt=%0d exp 0 0", pulses, err_count);
        end
    endtask

    task automatic test_single_flip();
        logic b;
        logic [CNT_W-1:0] exp_cnt;
        int pulses = 0;
`ifdef PRBS5_CHECKER_ERR_CNT_EN
        exp_cnt = err_count + 1'b1;
`else
        exp_cnt = '0;
`endif
        gen_bit(b);
        cycle(1'b1, ~b, 1'b0);
        if (bit_err === 1'b1) pulses++;
        for (int i = 0; i < 10; i++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0);
            if (bit_err === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || locked !== 1'b1 || err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL single_flip got pulses=%0d locked=%b cnt=%0d exp 1 1 %0d",
                     pulses, locked, err_count, exp_cnt);
        end
    endtask

    task automatic test_triple_flip();
        logic b;
        int relock = 0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (locked !== 1'b1) begin
                n_fail++;
                $display("FAIL triple_pre_lock flip=%0d got %b exp 1", i, locked);
            end
            gen_bit(b);
            cycle(1'b1, ~b, 1'b0);
        end
        n_tests++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL triple_drop got %b exp 0", locked);
        end
        for (int i = 1; i <= 30; i++) begin
            gen_bit(b);
            cycle(1'b1, b, 1'b0);
            if (locked === 1'b1 && relock == 0) relock = i;
        end
        n_tests++;
        if (relock != 5 + LOCK_MATCHES) begin
            n_fail++;
            $display("FAIL triple_relock got %0d exp %0d", relock, 5 + LOCK_MATCHES);
        end
    endtask

    task automatic test_stuck_zero();
        int ever = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) ever++;
        end
        n_tests++;
        if (ever != 0 || err_count !== '0) begin
            n_fail++;
            $display("FAIL stuck_zero got locked_cycles=%0d cnt=%0d exp 0 0", ever, err_count);
        end
    endtask

    task automatic test_valid_toggle();
        logic b;
        logic [CNT_W-1:0] cnt_before;
        int lock_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c % 2 == 0) begin
                gen_bit(b);
                cycle(1'b1, b, 1'b0);
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (locked === 1'b1 && lock_cyc == 0) lock_cyc = c;
        end
        n_tests++;
        if (lock_cyc != 2 * (5 + LOCK_MATCHES)) begin
            n_fail++;
            $display("FAIL toggle_lock_cycle got %0d exp %0d", lock_cyc, 2 * (5 + LOCK_MATCHES));
        end
        cnt_before = err_count;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        n_tests++;
        if (locked !== 1'b1 || err_count !== cnt_before || bit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got locked=%b cnt=%0d bit_err=%b exp 1 %0d 0",
                     locked, err_count, bit_err, cnt_before);
        end
    endtask

    task automatic test_clr_collision();
        logic b;
        clean_bits(5);
        gen_bit(b);
        cycle(1'b1, ~b, 1'b1);
        n_tests++;
        if (err_count !== '0 || bit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_collision got cnt=%0d bit_err=%b exp 0 1", err_count, bit_err);
        end
        clean_bits(5);
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if (locked !== 1'b0 || err_count !== '0 || state_dbg !== FILL) begin
            n_fail++;
            $display("FAIL async_reset got locked=%b cnt=%0d st=%0d exp 0 0 FILL",
                     locked, err_count, state_dbg);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_saturation();
        logic b;
        logic [CNT_W-1:0] exp_cnt;
        clean_bits(5 + LOCK_MATCHES);
        for (int i = 0; i < 40; i++) begin
            gen_bit(b);
            cycle(1'b1, (i % 2 == 0) ? ~b : b, 1'b0);
        end
`ifdef PRBS5_CHECKER_ERR_CNT_EN
        exp_cnt = ERR_MAX;
`else
        exp_cnt = '0;
`endif
        n_tests++;
        if (err_count !== exp_cnt || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation got cnt=%0d locked=%b exp %0d 1", err_count, locked, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic b;
        logic v;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                gen_bit(b);
                if ($urandom_range(0, 19) == 0) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            cycle(v, b, ($urandom_range(0, 29) == 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_triple_flip();
        test_clr_collision();
        test_async_reset();
        test_stuck_zero();
        test_reset();
        test_valid_toggle();
        test_reset();
        test_saturation();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs5_checker.md
PRBS5_CHECKER -- requirements
Module: prbs5_checker

Interface
REQ-001 Parameter LOCK_MATCHES, default 8: number of consecutive correct predictions needed to declare lock.
REQ-002 Parameter LOSS_ERRORS, default 3: number of consecutive mispredictions while locked that drops lock.
REQ-003 Parameter CNT_W, default 16: width of the error counter.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: in_bit is sampled on a clk edge only when in_valid is high.
REQ-007 Port in_bit, input, 1: received serial bit of the 5-bit LFSR stream.
REQ-008 Port err_clr, input, 1: synchronous clear of err_count.
REQ-009 Port locked, output, 1: registered; high while in LOCKED.
REQ-010 Port bit_err, output, 1: registered one-cycle pulse for a mispredicted valid bit while LOCKED.
REQ-011 Port err_count, output, CNT_W: registered, saturating count of bit_err pulses.

Function
REQ-012 Reference sequence: generator state s[4:0], output bit s[0], next state {s[0]^s[2], s[4:1]}, period 31; the equivalent recurrence is b[k] = b[k-5] ^ b[k-3].
REQ-013 Checker window r[4:0] holds the last 5 bits, with r[0] the oldest; prediction p = r[0] ^ r[2]; each accepted bit shifts r <= {x, r[4:1]}.
REQ-014 A cycle with in_valid low changes no state, counter or output, except that bit_err goes low and err_clr still acts.
REQ-015 FILL state: shift in_bit into r; after the 5th valid bit, go to SYNC with the match counter at 0.
REQ-016 SYNC state: shift in_bit into r (self-synchronising).
REQ-017 SYNC, in_bit == p and r != 0: increment the match counter.
REQ-018 SYNC, in_bit != p or r == 0: clear the match counter.
REQ-019 SYNC: on the LOCK_MATCHES-th consecutive match, go to LOCKED with the miss counter at 0.
REQ-020 An all-zero window never counts toward lock; this prevents lock on an idle or stuck-at-0 line.
REQ-021 LOCKED state: shift the predicted bit p into r (free-running), so errored input never corrupts the window.
REQ-022 LOCKED, in_bit == p: clear the miss counter.
REQ-023 LOCKED, in_bit != p: pulse bit_err the next cycle, increment err_count and increment the miss counter.
REQ-024 LOCKED: on the LOSS_ERRORS-th consecutive miss, go to FILL with r cleared and the fill count at 0; locked falls the same edge.
REQ-025 err_count saturates at all-ones and never wraps.
REQ-026 When err_clr and an error coincide, err_clr wins: err_count becomes 0, but bit_err still pulses.
REQ-027 Lock latency from reset release: locked rises on the edge that accepts valid bit number 5+LOCK_MATCHES of a clean stream (13 with defaults).

Reset
REQ-028 While reset is high: state = FILL, r = 0, all internal counters = 0, locked = 0, bit_err = 0, err_count = 0.
REQ-029 Reset asserted mid-operation, including while LOCKED, takes effect immediately without waiting for a clock edge; relock requires a full FILL+SYNC sequence.

Configuration
REQ-030 Macro PRBS5_CHECKER_ERR_CNT_EN defined: err_count and err_clr behave as in REQ-023, REQ-025 and REQ-026.
REQ-031 Macro PRBS5_CHECKER_ERR_CNT_EN undefined: no counter register is built, err_count is constant 0, err_clr is ignored, and the ports remain present.
REQ-032 Lock and bit_err behaviour is identical with and without PRBS5_CHECKER_ERR_CNT_EN.

Structure
REQ-033 Shared package prbs5_pkg holds: the state enum (FILL, SYNC, LOCKED), the LFSR width constant (5), the feedback tap constants (0 and 2), the seed 5'b00001, and a function next_state(s) used by both the checker and the benches.
REQ-034 One sub-module, prbs5_predictor, holds the window register r and the prediction p, with shift-source selection controlled by the checker FSM.

Verification
REQ-035 Clean stream from a generator seeded 5'b00001, in_valid always high -> locked rises after valid bit 13, bit_err never pulses, err_count = 0 after 100 bits.
REQ-036 Locked, then flip one bit -> exactly one bit_err pulse, err_count = 1, locked stays 1.
REQ-037 Locked, then flip 3 consecutive bits -> err_count = 3, locked falls on the 3rd; a clean stream then relocks after 13 more bits.
REQ-038 in_bit held at 0 for 200 valid cycles -> locked stays 0 and err_count stays 0.
REQ-039 Clean stream with in_valid toggling 1,0,1,0... -> locked rises after 13 valid bits (26 cycles); holding in_valid low changes nothing.
REQ-040 Cases for REQ-026 and REQ-029:
  - err_clr in the same cycle as an error -> err_count = 0.
  - Reset pulsed mid-clock while locked -> locked = 0 immediately, without waiting for a clock edge.
  - With the macro undefined, forced errors -> err_count stays 0.
